// File: rtl/float_pkg.sv
// ----------------------------------------------------------------------------
// float_pkg
//   Shared definitions for the single-precision float blocks (integer-to-float
//   converter, float adder pack/unpack paths).
//   Contents:
//     EXP_BIAS            IEEE-754 single exponent bias
//     SIGN_BIT/EXP_*/MANT_MSB  field positions inside the packed 32-bit word
//     cvt_state_e         converter FSM states; the encodings double as the
//                         debug codes driven on the converter's debug port
//     float_t             packed {sign, exp, mant} view of a float word
// ----------------------------------------------------------------------------
package float_pkg;

    localparam int EXP_BIAS = 127;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MANT_MSB = 22;

    localparam int EXP_W  = EXP_MSB - EXP_LSB + 1;
    localparam int MANT_W = MANT_MSB + 1;

    // State encodings are chosen to be readable on a logic analyser; they are
    // exported unchanged on the debug port.
    typedef enum logic [7:0] {
        ST_IDLE  = 8'h11,
        ST_ABS   = 8'h22,
        ST_NORM  = 8'h33,
        ST_ROUND = 8'h44,
        ST_OUT   = 8'h55
    } cvt_state_e;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } float_t;

endpackage : float_pkg

// File: rtl/fp_round_pack.sv
// ----------------------------------------------------------------------------
// fp_round_pack
//   Combinational round-and-pack stage. Takes a normalised 32-bit magnitude
//   (hidden bit in i_mag[31]), its biased exponent and sign, rounds the 24-bit
//   significand to nearest-even and packs the IEEE-754 single word.
//   Ports:
//     i_sign  in   1   sign of the result
//     i_exp   in   8   biased exponent of i_mag as presented
//     i_mag   in   32  normalised magnitude, i_mag[31] must be 1
//     o_data  out  32  packed float {sign, exp, mant}
// ----------------------------------------------------------------------------
module fp_round_pack
    import float_pkg::*;
(
    input  logic             i_sign,
    input  logic [EXP_W-1:0] i_exp,
    input  logic [31:0]      i_mag,
    output logic [31:0]      o_data
);

    logic        w_guard;
    logic        w_sticky;
    logic        w_round_up;
    logic [24:0] w_sig;
    logic        w_carry;
    float_t      w_pack;

    // Bits below the 24-bit significand: the first is the guard bit, the rest
    // collapse into a single sticky bit.
    assign w_guard    = i_mag[7];
    assign w_sticky   = |i_mag[6:0];
    assign w_round_up = w_guard & (w_sticky | i_mag[8]);

    // Significand including the hidden bit, one spare bit to catch the carry
    // when 1.111...1 rounds up to 10.000...0.
    assign w_sig   = {1'b0, i_mag[31:8]} + 25'(w_round_up);
    assign w_carry = w_sig[24];

    // On carry-out the significand is renormalised by one place right and the
    // exponent bumped; for this block the exponent never exceeds 158.
    assign w_pack.sign = i_sign;
    assign w_pack.exp  = i_exp + EXP_W'(w_carry);
    assign w_pack.mant = w_carry ? w_sig[23:1] : w_sig[22:0];

    assign o_data = w_pack;

endmodule : fp_round_pack

// File: rtl/int_to_float.sv
// ----------------------------------------------------------------------------
// int_to_float
//   Converts a signed 32-bit two's-complement integer to an IEEE-754 single
//   precision word. Iterative: the magnitude is normalised one bit per cycle,
//   then rounded to nearest-even and packed. One conversion in flight;
//   valid/ready handshakes on both sides.
//   Latency accept -> out_valid: lz+3 cycles (lz = leading zeros of the
//   magnitude), 1 cycle for a zero input.
//   Ports:
//     clk        in   1   rising-edge clock
//     reset      in   1   asynchronous, active-high reset
//     in_valid   in   1   in_data is valid
//     in_ready   out  1   converter idle, can accept an input
//     in_data    in   32  signed integer operand
//     out_valid  out  1   out_data holds a finished result
//     out_ready  in   1   consumer accepts out_data
//     out_data   out  32  packed float {sign, exp[7:0], mant[22:0]}
//     debug      out  32  current state code (IDLE=0x11 ... OUT=0x55)
// ----------------------------------------------------------------------------
module int_to_float
    import float_pkg::*;
#(
    parameter int INT_W    = 32,
    parameter int EXP_BIAS = 127
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [INT_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [31:0]      debug
);

    // Exponent of a magnitude whose MSB sits in bit INT_W-1 before any shift.
    localparam logic [EXP_W-1:0] EXP_INIT = EXP_W'(EXP_BIAS + INT_W - 1);

    cvt_state_e       r_state;
    cvt_state_e       w_state_next;

    logic             r_sign;
    logic [INT_W-1:0] r_value;
    logic [INT_W-1:0] r_mag;
    logic [EXP_W-1:0] r_exp;
    logic [31:0]      r_out_data;

    logic [INT_W-1:0] w_mag_abs;
    logic             w_mag_zero;
    logic [31:0]      w_packed;

    // Two's-complement negate; the most negative value maps onto itself, which
    // is exactly its unsigned magnitude.
    assign w_mag_abs  = r_sign ? (INT_W'(0) - r_value) : r_value;
    assign w_mag_zero = (w_mag_abs == '0);

    fp_round_pack u_round_pack (
        .i_sign (r_sign),
        .i_exp  (r_exp),
        .i_mag  (r_mag),
        .o_data (w_packed)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and handshake outputs
    // ------------------------------------------------------------------
    // NOTE: every signal driven here is given a default first so no path
    // through the case leaves it unassigned and infers a latch.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = ST_ABS;
                end
            end
            ST_ABS: begin
                w_state_next = w_mag_zero ? ST_OUT : ST_NORM;
            end
            ST_NORM: begin
                if (r_mag[INT_W-1]) begin
                    w_state_next = ST_ROUND;
                end
            end
            ST_ROUND: begin
                w_state_next = ST_OUT;
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    // NOTE: the datapath registers are reset as well as the state so an
    // aborted conversion leaves nothing behind and out_data reads zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sign     <= 1'b0;
            r_value    <= '0;
            r_mag      <= '0;
            r_exp      <= '0;
            r_out_data <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_sign  <= in_data[INT_W-1];
                        r_value <= in_data;
                    end
                end
                ST_ABS: begin
                    r_mag <= w_mag_abs;
                    r_exp <= EXP_INIT;
                    // Zero bypasses normalisation; always +0, never -0.
                    if (w_mag_zero) begin
                        r_out_data <= '0;
                    end
                end
                ST_NORM: begin
                    if (!r_mag[INT_W-1]) begin
                        r_mag <= r_mag << 1;
                        r_exp <= r_exp - EXP_W'(1);
                    end
                end
                ST_ROUND: begin
                    r_out_data <= w_packed;
                end
                default: begin
                end
            endcase
        end
    end

    assign out_data = r_out_data;
    assign debug    = 32'(r_state);

endmodule : int_to_float
